// File: rtl/sfx_scheduler.sv
// Audio path arbiter: BGM pass-through, or one of three two-note sound effects with preemption and queuing.
// Optional amplitude fade over the second half of an effect is enabled by defining SFX_FADE_EN.
module sfx_scheduler #(
    parameter int unsigned SFX_LEN    = 50_000_000,
    parameter int unsigned CNT_W      = 26,
    parameter logic [15:0] SFX_AMP    = 16'h2000,
    parameter logic [21:0] HIT_DIV_A  = 22'd191571,
    parameter logic [21:0] HIT_DIV_B  = 22'd151515,
    parameter logic [21:0] MISS_DIV_A = 22'd382219,
    parameter logic [21:0] MISS_DIV_B = 22'd454545,
    parameter logic [21:0] LVL_DIV_A  = 22'd151515,
    parameter logic [21:0] LVL_DIV_B  = 22'd113636
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic        mute,
    input  logic [21:0] bgm_note_div_left,
    input  logic [21:0] bgm_note_div_right,
    input  logic [15:0] bgm_amplitude,
    output logic [21:0] note_div_left,
    output logic [21:0] note_div_right,
    output logic [15:0] amplitude,
    output logic [2:0]  active_src,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(SFX_LEN / 2);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SFX_LEN - 1);
`ifdef SFX_FADE_EN
    localparam logic [CNT_W-1:0] Q3_C   = CNT_W'(3 * SFX_LEN / 4);
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        pending, pend_n, act_n;
    logic [2:0]        cand, win, hi, nw, keep;
    logic [21:0]       div_l_n, div_r_n, sfx_div;
    logic [15:0]       amp_n;

    function automatic logic [2:0] lowest(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pending;
        act_n   = active_src;
        cand    = req | pending;
        win     = lowest(cand);
        // For a one-hot source, (src - 1) masks exactly the higher-priority bits.
        hi      = req & (active_src - 3'd1);
        nw      = lowest(hi);
        keep    = (cnt < HALF_C) ? active_src : 3'b000;
        case (state)
            PLAY: begin
                if (hi != 3'b000) begin
                    act_n  = nw;
                    cnt_n  = '0;
                    pend_n = (pending | (req & ~active_src) | keep) & ~nw;
                end else if ((req & active_src) != 3'b000) begin
                    cnt_n  = '0;
                    pend_n = pending | (req & ~active_src);
                end else begin
                    pend_n = pending | (req & ~active_src);
                    if (cnt == LAST_C) begin
                        act_n   = 3'b000;
                        cnt_n   = '0;
                        state_n = (pend_n != 3'b000) ? GAP : IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (cand != 3'b000) begin
                    state_n = PLAY;
                    act_n   = win;
                    cnt_n   = '0;
                    pend_n  = cand & ~win;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // Output registers are loaded from next-state values so they line up with state/cnt.
    always_comb begin
        sfx_div = 22'd0;
        case (act_n)
            3'b001:  sfx_div = (cnt_n < HALF_C) ? HIT_DIV_A  : HIT_DIV_B;
            3'b010:  sfx_div = (cnt_n < HALF_C) ? MISS_DIV_A : MISS_DIV_B;
            3'b100:  sfx_div = (cnt_n < HALF_C) ? LVL_DIV_A  : LVL_DIV_B;
            default: sfx_div = 22'd0;
        endcase
        div_l_n = bgm_note_div_left;
        div_r_n = bgm_note_div_right;
        amp_n   = bgm_amplitude;
        case (state_n)
            PLAY: begin
                div_l_n = sfx_div;
                div_r_n = sfx_div;
                amp_n   = SFX_AMP;
`ifdef SFX_FADE_EN
                if (cnt_n >= Q3_C)
                    amp_n = SFX_AMP >> 2;
                else if (cnt_n >= HALF_C)
                    amp_n = SFX_AMP >> 1;
`endif
            end
            GAP: begin
                div_l_n = 22'd0;
                div_r_n = 22'd0;
                amp_n   = 16'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            pending        <= '0;
            active_src     <= '0;
            note_div_left  <= '0;
            note_div_right <= '0;
            amplitude      <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            pending        <= pend_n;
            active_src     <= act_n;
            note_div_left  <= div_l_n;
            note_div_right <= div_r_n;
            amplitude      <= mute ? 16'd0 : amp_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed self-checking bench for sfx_scheduler with SFX_LEN = 8.
module tb_sfx_scheduler;

    localparam logic [21:0] HA = 22'd191571, HB = 22'd151515;
    localparam logic [21:0] MA = 22'd382219, MB = 22'd454545;
    localparam logic [21:0] LA = 22'd151515, LB = 22'd113636;
    localparam logic [21:0] BGM_L = 22'd100, BGM_R = 22'd200;
    localparam logic [15:0] BGM_A = 16'h0444;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b000;
    logic        mute = 1'b0;
    logic [21:0] bgm_note_div_left = BGM_L, bgm_note_div_right = BGM_R;
    logic [15:0] bgm_amplitude = BGM_A;
    logic [21:0] note_div_left, note_div_right;
    logic [15:0] amplitude;
    logic [2:0]  active_src;
    logic        busy;

    int unsigned n_cmp = 0, n_bad = 0;
    logic [63:0] obs, exp_v;

    sfx_scheduler #(.SFX_LEN(8), .CNT_W(26)) dut (
        .clk(clk), .rst(rst), .req(req), .mute(mute),
        .bgm_note_div_left(bgm_note_div_left), .bgm_note_div_right(bgm_note_div_right),
        .bgm_amplitude(bgm_amplitude),
        .note_div_left(note_div_left), .note_div_right(note_div_right),
        .amplitude(amplitude), .active_src(active_src), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {div_l, div_r, amp, active_src, busy} while source src plays at count k.
    function automatic logic [63:0] e_play(input logic [2:0] src, input int k, input logic m);
        logic [21:0] d;
        logic [15:0] a;
        case (src)
            3'b001:  d = (k < 4) ? HA : HB;
            3'b010:  d = (k < 4) ? MA : MB;
            default: d = (k < 4) ? LA : LB;
        endcase
        a = 16'h2000;
`ifdef SFX_FADE_EN
        if (k >= 6) a = 16'h0800;
        else if (k >= 4) a = 16'h1000;
`endif
        if (m) a = 16'h0000;
        return {d, d, a, src, 1'b1};
    endfunction

    function automatic logic [63:0] e_idle(input logic m);
        return {BGM_L, BGM_R, (m ? 16'h0000 : BGM_A), 3'b000, 1'b0};
    endfunction

    function automatic logic [63:0] e_gap();
        return {44'd0, 16'd0, 3'b000, 1'b1};
    endfunction

    function automatic logic [63:0] sample();
        return {note_div_left, note_div_right, amplitude, active_src, busy};
    endfunction

    task automatic test_reset();
        req = 3'b001; tick(); req = 3'b000;
        tick(); tick();
        rst = 1'b0; #1;
        obs = sample(); exp_v = 64'd0; n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, exp_v); end
        #2 rst = 1'b1;
        tick();
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL reset_bgm: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_single_hit();
        req = 3'b001; tick(); req = 3'b000;
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b001, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL hit_k%0d: got %h want %h", k, obs, exp_v); end
            tick();
        end
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL hit_idle: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_simultaneous();
        req = 3'b110; tick(); req = 3'b000;
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b010, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL sim_miss_k%0d: got %h want %h", k, obs, exp_v); end
            tick();
        end
        obs = sample(); exp_v = e_gap(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL sim_gap: got %h want %h", obs, exp_v); end
        tick();
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b100, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL sim_lvl_k%0d: got %h want %h", k, obs, exp_v); end
            tick();
        end
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL sim_idle: got %h want %h", obs, exp_v); end
    endtask

    // Hit preempts level-up at count pk; level-up replays only when pk is in the first half.
    task automatic test_preempt(input int pk);
        req = 3'b100; tick(); req = 3'b000;
        for (int k = 0; k <= pk; k++) begin
            obs = sample(); exp_v = e_play(3'b100, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL pre%0d_lvl_k%0d: got %h want %h", pk, k, obs, exp_v); end
            if (k == pk) req = 3'b001;
            tick();
            req = 3'b000;
        end
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b001, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL pre%0d_hit_k%0d: got %h want %h", pk, k, obs, exp_v); end
            tick();
        end
        if (pk < 4) begin
            obs = sample(); exp_v = e_gap(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL pre%0d_gap: got %h want %h", pk, obs, exp_v); end
            tick();
            for (int k = 0; k < 8; k++) begin
                obs = sample(); exp_v = e_play(3'b100, k, 1'b0); n_cmp++;
                if (obs !== exp_v) begin n_bad++; $display("FAIL pre%0d_replay_k%0d: got %h want %h", pk, k, obs, exp_v); end
                tick();
            end
        end
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL pre%0d_idle: got %h want %h", pk, obs, exp_v); end
    endtask

    task automatic test_retrigger();
        req = 3'b001; tick(); req = 3'b000;
        for (int k = 0; k <= 6; k++) begin
            obs = sample(); exp_v = e_play(3'b001, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL rtg_first_k%0d: got %h want %h", k, obs, exp_v); end
            if (k == 6) req = 3'b001;
            tick();
            req = 3'b000;
        end
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b001, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL rtg_second_k%0d: got %h want %h", k, obs, exp_v); end
            tick();
        end
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL rtg_idle: got %h want %h", obs, exp_v); end
    endtask

    // Lower-priority miss arrives mid-hit, is queued, and a repeat of it is absorbed.
    task automatic test_low_pending();
        req = 3'b001; tick(); req = 3'b000;
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b001, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL low_hit_k%0d: got %h want %h", k, obs, exp_v); end
            if (k == 3 || k == 5) req = 3'b010;
            tick();
            req = 3'b000;
        end
        obs = sample(); exp_v = e_gap(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL low_gap: got %h want %h", obs, exp_v); end
        tick();
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b010, k, 1'b0); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL low_miss_k%0d: got %h want %h", k, obs, exp_v); end
            tick();
        end
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL low_idle: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_mute();
        mute = 1'b1;
        req = 3'b001; tick(); req = 3'b000;
        for (int k = 0; k < 8; k++) begin
            obs = sample(); exp_v = e_play(3'b001, k, 1'b1); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL mute_k%0d: got %h want %h", k, obs, exp_v); end
            tick();
        end
        obs = sample(); exp_v = e_idle(1'b1); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL mute_idle: got %h want %h", obs, exp_v); end
        mute = 1'b0;
        tick();
        obs = sample(); exp_v = e_idle(1'b0); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL unmute_idle: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        tick(); tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_preempt(2);
        test_preempt(5);
        test_retrigger();
        test_low_pending();
        test_mute();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
